// File: rtl/dvp_tx_gen.sv
// -----------------------------------------------------------------------------
// dvp_tx_gen
// DVP camera-port transmitter. Generates sensor-style VSYNC/HREF frame timing
// on a single pixel clock and pulls pixels from an upstream valid/ready source.
// Used as a stand-in sensor for capture-path bring-up and as a loopback source.
//
// Ports
//   I_clk          in   pixel clock, one pixel per cycle
//   I_rst_n        in   asynchronous active-low reset
//   I_enable       in   run request, sampled only at frame boundaries
//   I_pix_data     in   upstream pixel
//   I_pix_valid    in   upstream pixel valid
//   O_pix_ready    out  pixel consumed this cycle when high (combinational)
//   O_vsync        out  frame sync, asserted level = VS_POL
//   O_href         out  line valid, active-high
//   O_pixdata      out  pixel bus, zero whenever O_href is low
//   O_frame_start  out  one-cycle pulse on the first VSYNC-asserted cycle
//   O_underrun     out  sticky flag: an active pixel slot had no valid input
//   O_frame_cnt    out  completed frames, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module dvp_tx_gen #(
    parameter int   DATA_W   = 10,
    parameter int   H_ACTIVE = 640,
    parameter int   H_BLANK  = 160,
    parameter int   V_SYNC   = 4,
    parameter int   V_BACK   = 16,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter logic VS_POL   = 1'b0
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_enable,
    input  logic [DATA_W-1:0] I_pix_data,
    input  logic              I_pix_valid,
    output logic              O_pix_ready,
    output logic              O_vsync,
    output logic              O_href,
    output logic [DATA_W-1:0] O_pixdata,
    output logic              O_frame_start,
    output logic              O_underrun,
    output logic [15:0]       O_frame_cnt
);

    // Last index of each counter range; zero-length blanking states are skipped,
    // so their "last" values are never used and are clamped to zero.
    localparam logic [15:0] LP_H_LAST      = 16'(H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] LP_H_ACT       = 16'(H_ACTIVE);
    localparam logic [15:0] LP_VSYNC_LAST  = 16'(V_SYNC - 1);
    localparam logic [15:0] LP_VBACK_LAST  = (V_BACK > 0) ? 16'(V_BACK - 1) : 16'd0;
    localparam logic [15:0] LP_VACT_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] LP_VFRONT_LAST = (V_FRONT > 0) ? 16'(V_FRONT - 1) : 16'd0;
    localparam logic        LP_HAS_VBACK   = (V_BACK > 0);
    localparam logic        LP_HAS_VFRONT  = (V_FRONT > 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_hcnt;
    logic [15:0]         r_vcnt;
    logic                w_line_last;
    logic                w_frame_end;
    logic                w_pix_ready;
    logic                w_vsync_nxt;
    logic                w_fs_nxt;
    logic [DATA_W-1:0]   w_pixdata_nxt;

    logic                r_vsync;
    logic                r_href;
    logic [DATA_W-1:0]   r_pixdata;
    logic                r_frame_start;
    logic                r_underrun;
    logic [15:0]         r_frame_cnt;

    // End-of-line strobe; the horizontal counter is parked in IDLE.
    always_comb begin
        w_line_last = 1'b0;
        if ((r_state != ST_IDLE) && (r_hcnt == LP_H_LAST)) begin
            w_line_last = 1'b1;
        end else begin
            w_line_last = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; I_enable is only looked at in IDLE and at frame end.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (I_enable) begin
                    w_state_nxt = ST_VSYNC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_VSYNC: begin
                if (w_line_last && (r_vcnt == LP_VSYNC_LAST)) begin
                    w_state_nxt = LP_HAS_VBACK ? ST_VBACK : ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_VSYNC;
                end
            end
            ST_VBACK: begin
                if (w_line_last && (r_vcnt == LP_VBACK_LAST)) begin
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_VBACK;
                end
            end
            ST_ACTIVE: begin
                if (w_line_last && (r_vcnt == LP_VACT_LAST)) begin
                    if (LP_HAS_VFRONT) begin
                        w_state_nxt = ST_VFRONT;
                    end else begin
                        w_frame_end = 1'b1;
                        w_state_nxt = I_enable ? ST_VSYNC : ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_VFRONT: begin
                if (w_line_last && (r_vcnt == LP_VFRONT_LAST)) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = I_enable ? ST_VSYNC : ST_IDLE;
                end else begin
                    w_state_nxt = ST_VFRONT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_frame_end = 1'b0;
            end
        endcase
    end

    // FSM output logic: ready is combinational, the rest feed the output stage.
    always_comb begin
        w_pix_ready   = (r_state == ST_ACTIVE) && (r_hcnt < LP_H_ACT);
        w_fs_nxt      = (r_state == ST_VSYNC) && (r_vcnt == 16'd0) && (r_hcnt == 16'd0);
        w_vsync_nxt   = ~VS_POL;
        w_pixdata_nxt = {DATA_W{1'b0}};
        if (r_state == ST_VSYNC) begin
            w_vsync_nxt = VS_POL;
        end else begin
            w_vsync_nxt = ~VS_POL;
        end
        // A missing pixel still occupies its slot, driven as zero.
        if (w_pix_ready && I_pix_valid) begin
            w_pixdata_nxt = I_pix_data;
        end else begin
            w_pixdata_nxt = {DATA_W{1'b0}};
        end
    end

    // Horizontal and vertical counters; vcnt restarts on every state change.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_hcnt <= 16'd0;
            r_vcnt <= 16'd0;
        end else begin
            if ((r_state == ST_IDLE) || w_line_last) begin
                r_hcnt <= 16'd0;
            end else begin
                r_hcnt <= r_hcnt + 16'd1;
            end
            if (w_state_nxt != r_state) begin
                r_vcnt <= 16'd0;
            end else if (w_line_last) begin
                r_vcnt <= r_vcnt + 16'd1;
            end else begin
                r_vcnt <= r_vcnt;
            end
        end
    end

    // Registered output stage: VSYNC, HREF and data share one pipeline stage.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vsync       <= ~VS_POL;
            r_href        <= 1'b0;
            r_pixdata     <= {DATA_W{1'b0}};
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_vsync       <= w_vsync_nxt;
            r_href        <= w_pix_ready;
            r_pixdata     <= w_pixdata_nxt;
            r_frame_start <= w_fs_nxt;
            r_underrun    <= r_underrun | (w_pix_ready & ~I_pix_valid);
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    assign O_pix_ready   = w_pix_ready;
    assign O_vsync       = r_vsync;
    assign O_href        = r_href;
    assign O_pixdata     = r_pixdata;
    assign O_frame_start = r_frame_start;
    assign O_underrun    = r_underrun;
    assign O_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_dvp_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_dvp_tx_gen
// Directed bench for dvp_tx_gen with a reduced frame: 4 active + 3 blank clocks
// per line, 1 VSYNC line, 1 back-porch line, 2 active lines, 1 front-porch line,
// i.e. 35 clocks per frame. Observation index j counts cycles from the
// O_frame_start cycle (j = 0).
// -----------------------------------------------------------------------------
module tb_dvp_tx_gen;

    localparam int DW = 10;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          vsync;
    logic          href;
    logic [DW-1:0] pixdata;
    logic          frame_start;
    logic          underrun;
    logic [15:0]   frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int pix_k = 0;

    dvp_tx_gen #(
        .DATA_W(DW), .H_ACTIVE(4), .H_BLANK(3), .V_SYNC(1),
        .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1), .VS_POL(1'b0)
    ) dut (
        .I_clk         (clk),
        .I_rst_n       (rst_n),
        .I_enable      (enable),
        .I_pix_data    (pix_data),
        .I_pix_valid   (pix_valid),
        .O_pix_ready   (pix_ready),
        .O_vsync       (vsync),
        .O_href        (href),
        .O_pixdata     (pixdata),
        .O_frame_start (frame_start),
        .O_underrun    (underrun),
        .O_frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame shape, hand-derived from the small parameter set.
    function automatic logic exp_vsync(int j);
        return (j < 7) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_href(int j);
        return ((j >= 14) && (j <= 17)) || ((j >= 21) && (j <= 24));
    endfunction

    function automatic logic [DW-1:0] exp_data(int j);
        if ((j >= 14) && (j <= 17)) return DW'(j - 13);
        else if ((j >= 21) && (j <= 24)) return DW'(j - 20);
        else return {DW{1'b0}};
    endfunction

    // Advance to the next falling edge and present the next ramp value 1..4.
    task automatic tick();
        @(negedge clk);
        if (pix_ready) begin
            pix_data = DW'(pix_k + 1);
            pix_k    = (pix_k + 1) % 4;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_k = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync got %b want 1", vsync); end
        n_cmp++; if (href !== 1'b0) begin n_err++; $display("FAIL reset_href got %b want 0", href); end
        n_cmp++; if (pixdata !== 10'd0) begin n_err++; $display("FAIL reset_pixdata got %0d want 0", pixdata); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b want 0", frame_start); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b want 0", underrun); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", frame_cnt); end
        n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", pix_ready); end
        enable = 1'b1; pix_valid = 1'b1;
        rst_n  = 1'b1;
    endtask

    // Wait for a frame start, check one full frame, end on next frame's j = 0.
    task automatic test_frame(input logic [15:0] cnt_after);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (frame_start === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL frame_start_timeout got 0 want 1"); end
        n_cmp++; if (vsync !== 1'b0) begin n_err++; $display("FAIL frame_j0_vsync got %b want 0", vsync); end
        for (int j = 1; j < 35; j++) begin
            tick();
            n_cmp++; if (vsync !== exp_vsync(j)) begin n_err++; $display("FAIL frame_vsync j=%0d got %b want %b", j, vsync, exp_vsync(j)); end
            n_cmp++; if (href !== exp_href(j)) begin n_err++; $display("FAIL frame_href j=%0d got %b want %b", j, href, exp_href(j)); end
            n_cmp++; if (pixdata !== exp_data(j)) begin n_err++; $display("FAIL frame_data j=%0d got %0d want %0d", j, pixdata, exp_data(j)); end
            n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL frame_fs_extra j=%0d got %b want 0", j, frame_start); end
        end
        tick();
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL frame_fs_period got %b want 1", frame_start); end
        n_cmp++; if (frame_cnt !== cnt_after) begin n_err++; $display("FAIL frame_cnt got %0d want %0d", frame_cnt, cnt_after); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL frame_underrun got %b want 0", underrun); end
    endtask

    task automatic test_continuous();
        for (int f = 0; f < 2; f++) begin
            for (int i = 1; i <= 35; i++) begin
                tick();
                n_cmp++;
                if (frame_start !== (i == 35)) begin
                    n_err++; $display("FAIL cont_fs f=%0d i=%0d got %b want %b", f, i, frame_start, (i == 35));
                end
            end
        end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL cont_cnt got %0d want 3", frame_cnt); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL cont_underrun got %b want 0", underrun); end
    endtask

    task automatic test_underrun();
        logic [DW-1:0] want_d;
        for (int j = 1; j <= 34; j++) begin
            tick();
            want_d = (j == 15) ? 10'd0 : exp_data(j);
            n_cmp++; if (href !== exp_href(j)) begin n_err++; $display("FAIL ur_href j=%0d got %b want %b", j, href, exp_href(j)); end
            n_cmp++; if (pixdata !== want_d) begin n_err++; $display("FAIL ur_data j=%0d got %0d want %0d", j, pixdata, want_d); end
            n_cmp++; if (underrun !== (j >= 15)) begin n_err++; $display("FAIL ur_flag j=%0d got %b want %b", j, underrun, (j >= 15)); end
            pix_valid = (j == 14) ? 1'b0 : 1'b1;
        end
        tick();
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL ur_fs got %b want 1", frame_start); end
        n_cmp++; if (frame_cnt !== 16'd4) begin n_err++; $display("FAIL ur_cnt got %0d want 4", frame_cnt); end
    endtask

    task automatic test_disable();
        for (int j = 1; j <= 34; j++) begin
            tick();
            n_cmp++; if (vsync !== exp_vsync(j)) begin n_err++; $display("FAIL dis_vsync j=%0d got %b want %b", j, vsync, exp_vsync(j)); end
            n_cmp++; if (href !== exp_href(j)) begin n_err++; $display("FAIL dis_href j=%0d got %b want %b", j, href, exp_href(j)); end
            if (j == 16) enable = 1'b0;
        end
        for (int k = 1; k <= 50; k++) begin
            tick();
            n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL dis_idle_vsync k=%0d got %b want 1", k, vsync); end
            n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL dis_idle_fs k=%0d got %b want 0", k, frame_start); end
            n_cmp++; if (href !== 1'b0) begin n_err++; $display("FAIL dis_idle_href k=%0d got %b want 0", k, href); end
        end
        n_cmp++; if (frame_cnt !== 16'd5) begin n_err++; $display("FAIL dis_cnt got %0d want 5", frame_cnt); end
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL dis_sticky got %b want 1", underrun); end
    endtask

    task automatic test_reset_midline();
        logic found;
        enable = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (frame_start === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL rst_restart_timeout got 0 want 1"); end
        for (int j = 1; j <= 15; j++) tick();
        n_cmp++; if (href !== 1'b1) begin n_err++; $display("FAIL rst_pre_href got %b want 1", href); end
        n_cmp++; if (pixdata !== 10'd2) begin n_err++; $display("FAIL rst_pre_data got %0d want 2", pixdata); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (href !== 1'b0) begin n_err++; $display("FAIL rst_mid_href got %b want 0", href); end
        n_cmp++; if (pixdata !== 10'd0) begin n_err++; $display("FAIL rst_mid_data got %0d want 0", pixdata); end
        n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL rst_mid_vsync got %b want 1", vsync); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt got %0d want 0", frame_cnt); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_underrun got %b want 0", underrun); end
        repeat (2) @(negedge clk);
        pix_k = 0;
        rst_n = 1'b1;
        test_frame(16'd1);
    endtask

    task automatic test_cnt_wrap();
        for (int j = 1; j <= 35; j++) begin
            tick();
            if (j == 5) force dut.r_frame_cnt = 16'hFFFF;
            if (j == 6) begin
                release dut.r_frame_cnt;
                n_cmp++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got %h want ffff", frame_cnt); end
            end
            if (j == 33) begin
                n_cmp++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_hold got %h want ffff", frame_cnt); end
            end
        end
        n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame(16'd1);
        test_continuous();
        test_underrun();
        test_disable();
        test_reset_midline();
        test_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
